// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - serialising big-endian load/store unit on a byte-wide memory port
module load_store_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  AccessErr,
  output logic [ADDR_WIDTH-1:0] ByteAddr,
  output logic                  ByteRead,
  output logic                  ByteWrite,
  output logic [7:0]            ByteWData,
  input  logic [7:0]            ByteRData
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [31:0]           wdata_q;
  logic                  load_q;
  logic [1:0]            beat_q;
  logic                  err_q;
  logic                  rd_pend_q;
  logic [31:0]           acc_q;
  logic [31:0]           rdata_q;

  logic                  accept;
  logic                  req_err;
  logic [1:0]            last_beat;
  logic [1:0]            byte_sel;
  logic [31:0]           acc_next;
  logic [31:0]           ext;

  assign accept  = Start && (state_q == IDLE) && (MemRead ^ MemWrite);
  assign req_err = (Size == 2'b11) ||
                   (CHECK_ALIGN && (((Size == 2'b01) && Address[0]) ||
                                    ((Size == 2'b10) && (Address[1:0] != 2'b00))));

  // Beat index of the final byte: 0, 1 or 3; the byte sent in beat k is counted down from it
  assign last_beat = (size_q == 2'b00) ? 2'd0 : (size_q == 2'b01) ? 2'd1 : 2'd3;
  assign byte_sel  = last_beat - beat_q;
  assign acc_next  = {acc_q[23:0], ByteRData};

  // Next state plus all Moore outputs; strobes only ever come out of XFER
  always_comb begin
    state_d   = state_q;
    Busy      = (state_q != IDLE);
    Done      = (state_q == DONE);
    AccessErr = (state_q == DONE) && err_q;
    ByteRead  = 1'b0;
    ByteWrite = 1'b0;
    ByteAddr  = '0;
    ByteWData = 8'h00;
    case (state_q)
      IDLE: begin
        if (accept) state_d = req_err ? DONE : XFER;
      end
      XFER: begin
        ByteRead  = load_q;
        ByteWrite = !load_q;
        ByteAddr  = addr_q + ADDR_WIDTH'(beat_q);
        if (!load_q) ByteWData = wdata_q[{byte_sel, 3'b000} +: 8];
        if (beat_q == last_beat) state_d = load_q ? DRAIN : DONE;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sign/zero extension of the assembled value, using the byte arriving in DRAIN
  always_comb begin
    ext = acc_next;
    case (size_q)
      2'b00:   ext = {{24{!uns_q && acc_next[7]}}, acc_next[7:0]};
      2'b01:   ext = {{16{!uns_q && acc_next[15]}}, acc_next[15:0]};
      default: ext = acc_next;
    endcase
  end

  // Request capture, beat counting and big-endian assembly of returned bytes
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      wdata_q   <= 32'h0;
      load_q    <= 1'b0;
      beat_q    <= 2'd0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      acc_q     <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= ByteRead;
      if (accept) begin
        addr_q  <= Address;
        size_q  <= Size;
        uns_q   <= Unsigned;
        wdata_q <= WriteData;
        load_q  <= MemRead;
        beat_q  <= 2'd0;
        err_q   <= req_err;
      end else if (state_q == XFER) begin
        beat_q <= beat_q + 2'd1;
      end
      if (rd_pend_q) acc_q <= acc_next;
      if (state_q == DRAIN) rdata_q <= ext;
    end
  end

  assign ReadData = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        Start, MemRead, MemWrite, Unsigned;
  logic [1:0]  Size;
  logic [31:0] Address, WriteData, ReadData, ByteAddr;
  logic        Busy, Done, AccessErr, ByteRead, ByteWrite;
  logic [7:0]  ByteWData, ByteRData;

  logic        Start0, MemRead0, MemWrite0, Unsigned0;
  logic [1:0]  Size0;
  logic [31:0] Address0, WriteData0, ReadData0, ByteAddr0;
  logic        Busy0, Done0, AccessErr0, ByteRead0, ByteWrite0;
  logic [7:0]  ByteWData0, ByteRData0;

  logic [7:0]  mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_a;
  logic [7:0]  pre_d;

  int          n_checks = 0;
  int          n_errors = 0;

  int          done_cyc, n_rd, n_wr;
  logic        err_seen, busy_ok;
  logic [31:0] rd_addr [0:7];
  int          rd_cyc  [0:7];
  logic [31:0] wr_addr [0:7];
  logic [7:0]  wr_data [0:7];

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_WIDTH(32), .CHECK_ALIGN(1'b1)) dut (
    .clock(clock), .reset(reset), .Start(Start), .MemRead(MemRead), .MemWrite(MemWrite),
    .Size(Size), .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData), .Busy(Busy), .Done(Done), .AccessErr(AccessErr),
    .ByteAddr(ByteAddr), .ByteRead(ByteRead), .ByteWrite(ByteWrite),
    .ByteWData(ByteWData), .ByteRData(ByteRData)
  );

  load_store_unit #(.ADDR_WIDTH(32), .CHECK_ALIGN(1'b0)) dut0 (
    .clock(clock), .reset(reset), .Start(Start0), .MemRead(MemRead0), .MemWrite(MemWrite0),
    .Size(Size0), .Unsigned(Unsigned0), .Address(Address0), .WriteData(WriteData0),
    .ReadData(ReadData0), .Busy(Busy0), .Done(Done0), .AccessErr(AccessErr0),
    .ByteAddr(ByteAddr0), .ByteRead(ByteRead0), .ByteWrite(ByteWrite0),
    .ByteWData(ByteWData0), .ByteRData(ByteRData0)
  );

  // Byte memory: 4 KiB aliased by low address bits; read data one cycle after the strobe
  always @(posedge clock) begin
    if (pre_we)     mem[pre_a] <= pre_d;
    if (ByteWrite)  mem[ByteAddr[11:0]] <= ByteWData;
    if (ByteWrite0) mem[ByteAddr0[11:0]] <= ByteWData0;
    ByteRData  <= ByteRead  ? mem[ByteAddr[11:0]]  : 8'hA5;
    ByteRData0 <= ByteRead0 ? mem[ByteAddr0[11:0]] : 8'hA5;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clock); #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic ld, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clock);
    Start = 1'b1; MemRead = ld; MemWrite = !ld; Size = sz; Unsigned = uns;
    Address = a; WriteData = wd;
    @(posedge clock); #1;
    Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // Issue one request and log strobes and completion for up to 10 cycles after acceptance
  task automatic run_req(input logic ld, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    issue(ld, sz, uns, a, wd);
    done_cyc = 0; err_seen = 1'b0; n_rd = 0; n_wr = 0; busy_ok = 1'b1;
    for (int c = 1; c <= 10 && done_cyc == 0; c++) begin
      @(negedge clock);
      if (!Busy) busy_ok = 1'b0;
      if (ByteRead && n_rd < 8) begin rd_addr[n_rd] = ByteAddr; rd_cyc[n_rd] = c; n_rd++; end
      if (ByteWrite && n_wr < 8) begin wr_addr[n_wr] = ByteAddr; wr_data[n_wr] = ByteWData; n_wr++; end
      if (Done) begin done_cyc = c; err_seen = AccessErr; end
    end
  endtask

  initial begin
    logic [31:0] exp_wrap [0:3];
    logic [31:0] saved;
    int          nd0;
    int          n_rd0;
    logic [31:0] a0 [0:7];
    int          n_wr0;

    reset = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    Start = 0; MemRead = 0; MemWrite = 0; Size = 0; Unsigned = 0; Address = 0; WriteData = 0;
    Start0 = 0; MemRead0 = 0; MemWrite0 = 0; Size0 = 0; Unsigned0 = 0; Address0 = 0; WriteData0 = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_readdata", ReadData, 32'h0);
    check("rst_busy", {31'b0, Busy}, 32'h0);
    check("rst_done", {31'b0, Done}, 32'h0);
    check("rst_err", {31'b0, AccessErr}, 32'h0);
    check("rst_strobes", {30'b0, ByteRead, ByteWrite}, 32'h0);
    check("rst_addr_wdata", ByteAddr | {24'h0, ByteWData}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    poke(12'd40, 8'h00); poke(12'd41, 8'h00); poke(12'd42, 8'h00); poke(12'd43, 8'h64);

    run_req(1'b1, 2'b10, 1'b0, 32'd40, 32'h0);
    check("lw_nreads", n_rd, 32'd4);
    check("lw_first_cyc", rd_cyc[0], 32'd1);
    check("lw_last_cyc", rd_cyc[3], 32'd4);
    check("lw_addr0", rd_addr[0], 32'd40);
    check("lw_addr3", rd_addr[3], 32'd43);
    check("lw_done_cyc", done_cyc, 32'd6);
    check("lw_err", {31'b0, err_seen}, 32'h0);
    check("lw_busy", {31'b0, busy_ok}, 32'h1);
    check("lw_data", ReadData, 32'h00000064);
    @(negedge clock);
    check("after_done_busy", {31'b0, Busy}, 32'h0);
    check("after_done_pulse", {31'b0, Done}, 32'h0);

    poke(12'd43, 8'hF0);
    run_req(1'b1, 2'b00, 1'b0, 32'd43, 32'h0);
    check("lb_done_cyc", done_cyc, 32'd3);
    check("lb_data", ReadData, 32'hFFFFFFF0);
    run_req(1'b1, 2'b00, 1'b1, 32'd43, 32'h0);
    check("lbu_data", ReadData, 32'h000000F0);

    poke(12'd40, 8'h9C);
    run_req(1'b1, 2'b01, 1'b0, 32'd40, 32'h0);
    check("lh_done_cyc", done_cyc, 32'd4);
    check("lh_data", ReadData, 32'hFFFF9C00);
    run_req(1'b1, 2'b01, 1'b1, 32'd40, 32'h0);
    check("lhu_data", ReadData, 32'h00009C00);
    run_req(1'b1, 2'b10, 1'b1, 32'd40, 32'h0);
    check("lw_uns_ignored", ReadData, 32'h9C0000F0);

    run_req(1'b0, 2'b01, 1'b0, 32'h100, 32'hABCD1234);
    check("sh_done_cyc", done_cyc, 32'd3);
    check("sh_nwrites", n_wr, 32'd2);
    check("sh_nreads", n_rd, 32'd0);
    check("sh_wdata0", {24'h0, wr_data[0]}, 32'h12);
    check("sh_waddr1", wr_addr[1], 32'h101);
    check("sh_mem100", {24'h0, mem[12'h100]}, 32'h12);
    check("sh_mem101", {24'h0, mem[12'h101]}, 32'h34);
    check("sh_readdata_kept", ReadData, 32'h9C0000F0);

    run_req(1'b0, 2'b00, 1'b0, 32'h104, 32'h000000C3);
    check("sb_done_cyc", done_cyc, 32'd2);
    check("sb_mem104", {24'h0, mem[12'h104]}, 32'hC3);

    run_req(1'b1, 2'b10, 1'b0, 32'h2A, 32'h0);
    check("lw_mis_done_cyc", done_cyc, 32'd1);
    check("lw_mis_err", {31'b0, err_seen}, 32'h1);
    check("lw_mis_nreads", n_rd, 32'd0);
    check("lw_mis_readdata", ReadData, 32'h9C0000F0);
    @(negedge clock);
    check("err_pulse_len", {31'b0, AccessErr}, 32'h0);
    run_req(1'b1, 2'b11, 1'b0, 32'd40, 32'h0);
    check("sz11_done_cyc", done_cyc, 32'd1);
    check("sz11_err", {31'b0, err_seen}, 32'h1);
    check("sz11_nreads", n_rd, 32'd0);
    run_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0000FFFF);
    check("sh_mis_err", {31'b0, err_seen}, 32'h1);
    check("sh_mis_nwrites", n_wr, 32'd0);
    check("sh_mis_mem", {24'h0, mem[12'h101]}, 32'h34);

    @(negedge clock);
    Start = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clock); #1;
    Start = 1'b0;
    @(negedge clock);
    check("start_no_dir", {31'b0, Busy}, 32'h0);
    Start = 1'b1; MemRead = 1'b1; MemWrite = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clock);
    check("start_both_dir", {31'b0, Busy}, 32'h0);

    poke(12'h202, 8'h77); poke(12'h203, 8'h77);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h11223344);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    nd0 = 0;
    check("rst_mid_busy", {31'b0, Busy}, 32'h0);
    check("rst_mid_strobe", {31'b0, ByteWrite}, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (Done || Busy || ByteWrite) nd0++;
    end
    check("rst_mid_quiet", nd0, 32'd0);
    check("rst_mid_m200", {24'h0, mem[12'h200]}, 32'h11);
    check("rst_mid_m201", {24'h0, mem[12'h201]}, 32'h22);
    check("rst_mid_m202", {24'h0, mem[12'h202]}, 32'h77);
    check("rst_mid_m203", {24'h0, mem[12'h203]}, 32'h77);

    poke(12'hFFE, 8'hDE); poke(12'hFFF, 8'hAD); poke(12'h000, 8'hBE); poke(12'h001, 8'hEF);
    poke(12'h300, 8'h5C);
    exp_wrap[0] = 32'hFFFFFFFE; exp_wrap[1] = 32'hFFFFFFFF;
    exp_wrap[2] = 32'h00000000; exp_wrap[3] = 32'h00000001;
    @(negedge clock);
    Start0 = 1'b1; MemRead0 = 1'b1; MemWrite0 = 1'b0; Size0 = 2'b10; Address0 = 32'hFFFFFFFE;
    @(posedge clock); #1;
    Start0 = 1'b0; MemRead0 = 1'b0;
    nd0 = 0; n_rd0 = 0; n_wr0 = 0; done_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (ByteRead0 && n_rd0 < 8) begin a0[n_rd0] = ByteAddr0; n_rd0++; end
      if (ByteWrite0) n_wr0++;
      if (Done0) begin nd0++; if (done_cyc == 0) done_cyc = c; end
      Start0 = 1'b0; MemWrite0 = 1'b0;
      if (c == 2) begin
        Start0 = 1'b1; MemWrite0 = 1'b1; Size0 = 2'b00; Address0 = 32'h300; WriteData0 = 32'h99;
      end
    end
    check("wrap_nreads", n_rd0, 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("wrap_addr%0d", i), a0[i], exp_wrap[i]);
    check("wrap_done_cyc", done_cyc, 32'd6);
    check("wrap_data", ReadData0, 32'hDEADBEEF);
    check("busy_start_ignored", nd0, 32'd1);
    check("busy_start_nowrite", n_wr0, 32'd0);
    check("busy_start_mem", {24'h0, mem[12'h300]}, 32'h5C);
    saved = {31'b0, Busy0};
    check("wrap_idle", saved, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
